// File: rtl/axil_regbank_pkg.sv
// Shared definitions for the axil_regbank AXI4-Lite register bank:
// response codes, write/read FSM state types and the byte-strobe mask helper.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'b00,
    W_COLLECT = 2'b01,
    W_RESP    = 2'b10
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axil_regbank_wr_collect.sv
// Independent capture of the AXI4-Lite AW and W channels for axil_regbank.
// Each channel is latched on its own handshake; both_held flags a complete write.
module axil_regbank_wr_collect
  import axil_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  hold_off,
  input  logic                  clear,
  output logic                  aw_hs,
  output logic                  w_hs,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           data,
  output logic [3:0]            strb,
  output logic                  both_held
);

  logic aw_held;
  logic w_held;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign both_held = aw_held && w_held;

  // Address channel: latch on handshake, ready only while idle and not held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      addr    <= {ADDR_WIDTH{1'b0}};
      awready <= 1'b0;
    end else begin
      if (clear) begin
        aw_held <= 1'b0;
      end else if (aw_hs) begin
        aw_held <= 1'b1;
        addr    <= awaddr;
      end
      awready <= !hold_off && !aw_hs && !aw_held;
    end
  end

  // Data channel: same scheme as the address channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_held <= 1'b0;
      data   <= 32'h0000_0000;
      strb   <= 4'h0;
      wready <= 1'b0;
    end else begin
      if (clear) begin
        w_held <= 1'b0;
      end else if (w_hs) begin
        w_held <= 1'b1;
        data   <= wdata;
        strb   <= wstrb;
      end
      wready <= !hold_off && !w_hs && !w_held;
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank: NUM_CFG RW config words, NUM_STAT RO status words.
// Optional macro AXIL_REGS_SHADOW_EN: writes land in a shadow bank, applied by a COMMIT word.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int                      ADDR_WIDTH = 8,
  parameter int                      NUM_CFG    = 8,
  parameter int                      NUM_STAT   = 4,
  parameter logic [NUM_CFG*32-1:0]   CFG_RESET  = {NUM_CFG*32{1'b0}}
) (
  input  logic                                        axi_clk,
  input  logic                                        axi_rstn,
  input  logic [ADDR_WIDTH-1:0]                       axi_awaddr,
  input  logic [2:0]                                  axi_awprot,
  input  logic                                        axi_awvalid,
  output logic                                        axi_awready,
  input  logic [31:0]                                 axi_wdata,
  input  logic [3:0]                                  axi_wstrb,
  input  logic                                        axi_wvalid,
  output logic                                        axi_wready,
  output logic [1:0]                                  axi_bresp,
  output logic                                        axi_bvalid,
  input  logic                                        axi_bready,
  input  logic [ADDR_WIDTH-1:0]                       axi_araddr,
  input  logic [2:0]                                  axi_arprot,
  input  logic                                        axi_arvalid,
  output logic                                        axi_arready,
  output logic [31:0]                                 axi_rdata,
  output logic [1:0]                                  axi_rresp,
  output logic                                        axi_rvalid,
  input  logic                                        axi_rready,
  output logic [NUM_CFG*32-1:0]                       cfg_regs,
  output logic [NUM_CFG-1:0]                          cfg_wr_pulse,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*32-1:0] stat_regs
);

  localparam logic [31:0] CFG_N    = 32'(NUM_CFG);
  localparam logic [31:0] STAT_END = 32'(NUM_CFG + NUM_STAT);

  wr_state_t wr_state;
  wr_state_t wr_next;
  rd_state_t rd_state;
  rd_state_t rd_next;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  both_held;
  logic                  fire;
  logic                  hold_off;
  logic                  b_hs;
  logic                  ar_hs;
  logic                  r_hs;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [31:0]           wmask;
  logic [31:0]           widx;
  logic [31:0]           ridx;
  logic                  wr_is_cfg;
  logic                  wr_is_commit;
  logic                  wr_ok;
  logic [NUM_CFG*32-1:0] cfg_q;
  logic [NUM_CFG*32-1:0] bank;
  logic [NUM_CFG*32-1:0] bank_next;
  logic [NUM_CFG-1:0]    pulse_next;
  logic [31:0]           rd_word;
  logic [1:0]            rd_resp;
  logic                  unused_bits;

  assign unused_bits = ^{axi_awprot, axi_arprot, wr_addr[1:0], axi_araddr[1:0]};

  axil_regbank_wr_collect #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wr_collect (
    .clk      (axi_clk),
    .rst_n    (axi_rstn),
    .awaddr   (axi_awaddr),
    .awvalid  (axi_awvalid),
    .awready  (axi_awready),
    .wdata    (axi_wdata),
    .wstrb    (axi_wstrb),
    .wvalid   (axi_wvalid),
    .wready   (axi_wready),
    .hold_off (hold_off),
    .clear    (fire),
    .aw_hs    (aw_hs),
    .w_hs     (w_hs),
    .addr     (wr_addr),
    .data     (wr_data),
    .strb     (wr_strb),
    .both_held(both_held)
  );

  assign widx      = 32'(wr_addr[ADDR_WIDTH-1:2]);
  assign ridx      = 32'(axi_araddr[ADDR_WIDTH-1:2]);
  assign wmask     = strb_to_mask(wr_strb);
  assign b_hs      = axi_bvalid && axi_bready;
  assign ar_hs     = axi_arvalid && axi_arready;
  assign r_hs      = axi_rvalid && axi_rready;
  assign fire      = (wr_state == W_COLLECT) && both_held;
  // Readies stay low from the write cycle until the B handshake completes
  assign hold_off  = fire || ((wr_state == W_RESP) && !b_hs);
  assign wr_is_cfg = (widx < CFG_N);
  assign wr_ok     = wr_is_cfg || wr_is_commit;
  assign cfg_regs  = cfg_q;

`ifdef AXIL_REGS_SHADOW_EN
  logic                  commit;
  logic [NUM_CFG*32-1:0] shadow_q;

  assign wr_is_commit = (widx == STAT_END);
  assign commit       = fire && wr_is_commit && wr_strb[0] && wr_data[0];
  assign bank         = shadow_q;

  // Shadow bank takes all config writes
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      shadow_q <= CFG_RESET;
    end else begin
      shadow_q <= bank_next;
    end
  end

  // Live config copies the shadow bank on commit
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cfg_q <= CFG_RESET;
    end else if (commit) begin
      cfg_q <= shadow_q;
    end
  end
`else
  assign wr_is_commit = 1'b0;
  assign bank         = cfg_q;

  // Live config takes writes directly
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cfg_q <= CFG_RESET;
    end else begin
      cfg_q <= bank_next;
    end
  end
`endif

  // Byte-merge the held write into the addressed word and flag its pulse
  always_comb begin
    bank_next  = bank;
    pulse_next = {NUM_CFG{1'b0}};
    for (int n = 0; n < NUM_CFG; n++) begin
      if (fire && wr_is_cfg && (widx == 32'(n))) begin
        bank_next[n*32 +: 32] = (bank[n*32 +: 32] & ~wmask) | (wr_data & wmask);
        pulse_next[n]         = 1'b1;
      end else begin
        bank_next[n*32 +: 32] = bank[n*32 +: 32];
        pulse_next[n]         = 1'b0;
      end
    end
`ifdef AXIL_REGS_SHADOW_EN
    pulse_next = commit ? {NUM_CFG{1'b1}} : {NUM_CFG{1'b0}};
`endif
  end

  // Write pulse register
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cfg_wr_pulse <= {NUM_CFG{1'b0}};
    end else begin
      cfg_wr_pulse <= pulse_next;
    end
  end

  // Write FSM state register
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      wr_state <= W_IDLE;
    end else begin
      wr_state <= wr_next;
    end
  end

  // Write FSM next state
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs || w_hs) begin
          wr_next = W_COLLECT;
        end else begin
          wr_next = W_IDLE;
        end
      end
      W_COLLECT: begin
        if (both_held) begin
          wr_next = W_RESP;
        end else begin
          wr_next = W_COLLECT;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wr_next = W_IDLE;
        end else begin
          wr_next = W_RESP;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // B channel registers
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
    end else if (fire) begin
      axi_bvalid <= 1'b1;
      axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs) begin
      axi_bvalid <= 1'b0;
    end
  end

  // Read decode; samples the pre-write bank and live status inputs
  always_comb begin
    rd_word = 32'h0000_0000;
    for (int n = 0; n < NUM_CFG; n++) begin
      rd_word = rd_word | ((ridx == 32'(n)) ? bank[n*32 +: 32] : 32'h0000_0000);
    end
    for (int n = 0; n < NUM_STAT; n++) begin
      rd_word = rd_word | ((ridx == (CFG_N + 32'(n))) ? stat_regs[n*32 +: 32] : 32'h0000_0000);
    end
`ifdef AXIL_REGS_SHADOW_EN
    rd_resp = (ridx <= STAT_END) ? RESP_OKAY : RESP_SLVERR;
`else
    rd_resp = (ridx < STAT_END) ? RESP_OKAY : RESP_SLVERR;
`endif
  end

  // Read FSM state register
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  // Read FSM next state
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: begin
        if (ar_hs) begin
          rd_next = R_DATA;
        end else begin
          rd_next = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          rd_next = R_IDLE;
        end else begin
          rd_next = R_DATA;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // AR/R channel registers
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= 32'h0000_0000;
      axi_rresp   <= RESP_OKAY;
    end else if (ar_hs) begin
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b1;
      axi_rdata   <= rd_word;
      axi_rresp   <= rd_resp;
    end else if (r_hs) begin
      axi_rvalid  <= 1'b0;
      axi_arready <= 1'b1;
    end else if (rd_state == R_IDLE) begin
      axi_arready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Directed self-checking bench for axil_regbank (default build, 8 config / 4 status words).
module tb_axil_regbank;
  import axil_regbank_pkg::*;

  localparam int AW = 8;
  localparam int NC = 8;
  localparam int NS = 4;
  localparam logic [NC*32-1:0] CFG_RST = {32'hCAFE_0007, 224'h0};

  logic            clk = 1'b0;
  logic            rstn;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;
  logic [NC*32-1:0] cfg_regs;
  logic [NC-1:0]   cfg_wr_pulse;
  logic [NS*32-1:0] stat_regs;

  always #5 clk = ~clk;

  axil_regbank #(.ADDR_WIDTH(AW), .NUM_CFG(NC), .NUM_STAT(NS), .CFG_RESET(CFG_RST)) dut (
    .axi_clk(clk), .axi_rstn(rstn),
    .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .stat_regs(stat_regs)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  logic [NC-1:0] pulse_last = '0;

  // Counts cycles with any write pulse and remembers the last pattern
  always @(posedge clk) begin
    if (cfg_wr_pulse != '0) begin
      pulse_cnt  <= pulse_cnt + 1;
      pulse_last <= cfg_wr_pulse;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] cfgw(input int i);
    return cfg_regs[i*32 +: 32];
  endfunction

  // Called at a falling edge; presents AW after aw_dly cycles and W after w_dly cycles
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int t = 0;
    while (!(aw_done && w_done) && t < 40) begin
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      @(negedge clk);
      t++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_eq("aw_w_accepted", 64'(aw_done && w_done), 64'd1);
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp);
    int t = 0;
    bready = (hold == 0);
    while (!bvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("bvalid_seen", 64'(bvalid), 64'd1);
    resp = bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("b_hold_bvalid", 64'(bvalid), 64'd1);
      check_eq("b_hold_bresp", 64'(bresp), 64'(resp));
      check_eq("b_hold_awready", 64'(awready), 64'd0);
    end
    bready = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t = 0;
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    while (!arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("arready_seen", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("rvalid_seen", 64'(rvalid), 64'd1);
    d    = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]       r;
    logic [31:0]      d;
    int               p0;
    logic [NC*32-1:0] snap;
    bit               saw_b;

    rstn = 1'b0; awaddr = '0; araddr = '0; awprot = 3'b000; arprot = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = 4'h0; bready = 1'b1;
    arvalid = 1'b0; rready = 1'b1;
    stat_regs = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1234_5678};
    repeat (3) @(negedge clk);

    check_eq("rst_awready", 64'(awready), 64'd0);
    check_eq("rst_wready", 64'(wready), 64'd0);
    check_eq("rst_arready", 64'(arready), 64'd0);
    check_eq("rst_bvalid", 64'(bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    check_eq("rst_pulse", 64'(cfg_wr_pulse), 64'd0);
    check_eq("rst_cfg_all", 64'(cfg_regs == CFG_RST), 64'd1);
    check_eq("rst_cfg7", 64'(cfgw(7)), 64'hCAFE_0007);

    rstn = 1'b1;
    @(negedge clk);
    check_eq("post_rst_awready", 64'(awready), 64'd1);
    check_eq("post_rst_wready", 64'(wready), 64'd1);
    check_eq("post_rst_arready", 64'(arready), 64'd1);

    // AW first, W three cycles later
    p0 = pulse_cnt;
    do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 3);
    wait_b(0, r);
    check_eq("w1_bresp", 64'(r), 64'(RESP_OKAY));
    check_eq("w1_word1", 64'(cfgw(1)), 64'hDEAD_BEEF);
    check_eq("w1_pulse_cycles", 64'(pulse_cnt - p0), 64'd1);
    check_eq("w1_pulse_bits", 64'(pulse_last), 64'h02);
    do_read(8'h04, d, r);
    check_eq("r1_data", 64'(d), 64'hDEAD_BEEF);
    check_eq("r1_resp", 64'(r), 64'(RESP_OKAY));

    // W before AW, then a partial-strobe merge
    do_write(8'h08, 32'hAABB_CCDD, 4'hF, 2, 0);
    wait_b(0, r);
    do_write(8'h08, 32'h1122_3344, 4'b0101, 0, 0);
    wait_b(0, r);
    check_eq("w2_bresp", 64'(r), 64'(RESP_OKAY));
    check_eq("w2_word2", 64'(cfgw(2)), 64'hAA22_CC44);
    do_read(8'h0B, d, r);
    check_eq("r2_data_lowbits", 64'(d), 64'hAA22_CC44);

    // Status words and write to status
    do_read(8'h20, d, r);
    check_eq("stat0_data", 64'(d), 64'h1234_5678);
    check_eq("stat0_resp", 64'(r), 64'(RESP_OKAY));
    do_read(8'h2C, d, r);
    check_eq("stat3_data", 64'(d), 64'h4444_0003);
    snap = cfg_regs;
    p0 = pulse_cnt;
    do_write(8'h20, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wait_b(0, r);
    check_eq("stat_wr_bresp", 64'(r), 64'(RESP_SLVERR));
    check_eq("stat_wr_nopulse", 64'(pulse_cnt - p0), 64'd0);
    check_eq("stat_wr_nochange", 64'(cfg_regs == snap), 64'd1);

    // Unmapped reads and the first index past status
    do_read(8'hFC, d, r);
    check_eq("unmap_fc_data", 64'(d), 64'd0);
    check_eq("unmap_fc_resp", 64'(r), 64'(RESP_SLVERR));
    do_read(8'h30, d, r);
    check_eq("unmap_30_resp", 64'(r), 64'(RESP_SLVERR));
    do_read(8'h1F, d, r);
    check_eq("word7_reset_read", 64'(d), 64'hCAFE_0007);

    // Zero strobe still pulses
    p0 = pulse_cnt;
    do_write(8'h10, 32'hFFFF_FFFF, 4'h0, 0, 0);
    wait_b(0, r);
    check_eq("strb0_bresp", 64'(r), 64'(RESP_OKAY));
    check_eq("strb0_word4", 64'(cfgw(4)), 64'd0);
    check_eq("strb0_pulse", 64'(pulse_last), 64'h10);
    check_eq("strb0_pulse_cycles", 64'(pulse_cnt - p0), 64'd1);

    // Back-pressure on B
    do_write(8'h14, 32'h0000_0055, 4'hF, 0, 0);
    wait_b(10, r);
    check_eq("bhold_resp", 64'(r), 64'(RESP_OKAY));
    check_eq("bhold_word5", 64'(cfgw(5)), 64'h55);

    // Read lands on the same cycle as the write to the same word
    awaddr = 8'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h0C; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check_eq("coll_rvalid", 64'(rvalid), 64'd1);
    check_eq("coll_rdata_old", 64'(rdata), 64'd0);
    check_eq("coll_bvalid", 64'(bvalid), 64'd1);
    check_eq("coll_word3", 64'(cfgw(3)), 64'h5);
    @(negedge clk);
    check_eq("coll_rvalid_done", 64'(rvalid), 64'd0);
    check_eq("coll_bvalid_done", 64'(bvalid), 64'd0);
    do_read(8'h0C, d, r);
    check_eq("coll_reread", 64'(d), 64'h5);

    // Reset between AW and W
    awaddr = 8'h10; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check_eq("mid_awready_low", 64'(awready), 64'd0);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_cfg", 64'(cfg_regs == CFG_RST), 64'd1);
    rstn = 1'b1;
    saw_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bvalid) saw_b = 1'b1;
    end
    check_eq("mid_rst_no_b", 64'(saw_b), 64'd0);
    check_eq("mid_rst_awready", 64'(awready), 64'd1);
    check_eq("mid_rst_word1", 64'(cfgw(1)), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_regbank.md
Name: axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank; successor to the fixed 3-register config slave in the XDMA stream data-generator IP. Provides NUM_CFG read/write config words, NUM_STAT read-only status words, per-word write pulses and error responses for bad accesses. Sits between the PCIe/XDMA AXI-Lite BAR master and the data-generator datapath.

Parameters:
ADDR_WIDTH, 8, byte-address width of AW/AR channels (word index = addr[ADDR_WIDTH-1:2])
NUM_CFG, 8, number of 32-bit RW config registers (1..64)
NUM_STAT, 4, number of 32-bit RO status registers (0..64)
CFG_RESET, {NUM_CFG*32{1'b0}}, packed reset value of config registers

Ports:
axi_clk  in  1  clock
axi_rstn  in  1  async active-low reset
axi_awaddr  in  ADDR_WIDTH  write address
axi_awprot  in  3  ignored
axi_awvalid / axi_awready  in/out  1  AW handshake
axi_wdata  in  32  write data
axi_wstrb  in  4  byte enables
axi_wvalid / axi_wready  in/out  1  W handshake
axi_bresp  out  2  write response
axi_bvalid / axi_bready  out/in  1  B handshake
axi_araddr  in  ADDR_WIDTH  read address
axi_arprot  in  3  ignored
axi_arvalid / axi_arready  in/out  1  AR handshake
axi_rdata  out  32  read data
axi_rresp  out  2  read response
axi_rvalid / axi_rready  out/in  1  R handshake
cfg_regs  out  NUM_CFG*32  packed config words, word n at [n*32+:32]
cfg_wr_pulse  out  NUM_CFG  one-cycle pulse per config word written
stat_regs  in  NUM_STAT*32  packed status words, sampled on read

Behaviour:
- One clock axi_clk; reset axi_rstn asynchronous, active-low. All state async-cleared; outputs leave reset at: all ready/valid 0, bresp/rresp 2'b00, rdata 0, cfg_regs = CFG_RESET, cfg_wr_pulse 0.
- Map: word idx = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. idx < NUM_CFG -> config; NUM_CFG <= idx < NUM_CFG+NUM_STAT -> status; else unmapped.
- Write FSM states W_IDLE, W_COLLECT, W_RESP. W_IDLE: awready=wready=1 from first cycle after reset. AW and W accepted independently, in either order or same cycle; each latched and its ready dropped on handshake. When both held: perform write that cycle, go W_RESP with bvalid=1 next cycle.
- Write effect: config word updated byte-wise per wstrb; cfg_wr_pulse[idx]=1 for exactly the cycle after update (even if wstrb=0, bresp OKAY). Status or unmapped idx: no state change, no pulse, bresp=2'b10 SLVERR.
- W_RESP: hold bvalid/bresp until bready; on handshake bvalid=0, readies reasserted next cycle. Max one outstanding write; AW/W not accepted while bvalid high.
- Read FSM R_IDLE, R_DATA. arready=1 in R_IDLE. On AR handshake: arready=0, next cycle rvalid=1 with rdata = config / status word (stat_regs sampled at handshake cycle), rresp OKAY; unmapped -> rdata 0, rresp SLVERR. rdata/rresp stable until rready; then rvalid=0, arready=1 next cycle.
- Read and write channels fully independent; a read of a word being written the same cycle returns the pre-write value.
- Reset asserted mid-transaction: in-flight transaction dropped, no partial write, no response issued.

Optional Feature:
AXIL_REGS_SHADOW_EN: defined -> writes go to a shadow bank; cfg_regs updates from shadow only on a write with wstrb[0]=1 and wdata[0]=1 to a dedicated COMMIT word at idx = NUM_CFG+NUM_STAT (reads return 0), and cfg_wr_pulse fires for all words on commit; reads of config return shadow values. Undefined -> cfg_regs updated directly as above; COMMIT idx is unmapped (SLVERR).

Decomposition:
- Package axil_regbank_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read state enums, function strb_to_mask(4b)->32b byte mask.
- Sub-module axil_regbank_wr_collect: AW/W independent capture with latched addr/data/strb and "both held" flag.

Test Plan:
- Write 0xDEADBEEF to 0x04, wstrb 4'hF, AW then W 3 cycles later -> bresp OKAY, cfg word1=0xDEADBEEF, cfg_wr_pulse=8'h02 one cycle, read 0x04 returns same.
- Write 0x11223344 to 0x08 with wstrb 4'b0101 over 0xAABBCCDD -> word2=0xAA22CC44.
- stat_regs word0=0x12345678, read 0x20 (NUM_CFG=8) -> rdata 0x12345678 OKAY; write 0x20 -> SLVERR, no pulse.
- Read 0xFC -> rdata 0 SLVERR; bready held low 10 cycles on a write -> bvalid/bresp stable, awready stays 0.
- Simultaneous AR to 0x0C and AW+W to 0x0C data 0x5 (old 0x0) -> rdata 0x0, word3=0x5 afterwards.
- Assert axi_rstn low after AW accepted, before W -> all regs CFG_RESET, no bvalid after release.
